sysid_checker_master: RTL and testbench
=======================================

// Module: sysid_checker_master
// PURPOSE
//  Avalon-MM master that reads the system-ID peripheral (word 0 = ID, word 1 = timestamp)
//  after reset or on request, and compares both words against expected values.
//  Sits beside the Nios/HPS side of the StepperMotorControl system. Its flags gate
//  motor-enable logic so the drive runs only with a matching hardware image.
// PARAMETERS
//  EXP_ID       32'h0400_0000  expected word at address 0
//  EXP_TS       32'h5465_DE70  expected word at address 1
//  AUTO_START   1              1: run one check automatically after reset release
//  TIMEOUT_CYC  1024           max cycles per read (request + response) before abort; >=2
// PORTS
//  clock              in   1   system clock
//  reset              in   1   asynchronous, active-high reset
//  start              in   1   1-cycle pulse: begin a check (ignored while busy)
//  avm_address        out  1   word address to sysid slave (0=ID, 1=TS)
//  avm_read           out  1   read request; held until waitrequest low
//  avm_waitrequest    in   1   slave stall
//  avm_readdata       in   32  read data, valid when avm_readdatavalid=1
//  avm_readdatavalid  in   1   response strobe
//  busy               out  1   check in progress
//  done               out  1   1-cycle pulse at end of check (pass, fail or timeout)
//  id_ok              out  1   sticky: last check ID matched
//  ts_ok              out  1   sticky: last check timestamp matched
//  timeout            out  1   sticky: last check aborted on timeout
//  read_id            out  32  captured ID word
//  read_ts            out  32  captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; timeout counter 0. Reset mid-read aborts without a
//   done pulse; a late readdatavalid after reset is ignored (arrives in IDLE).
//  FSM: IDLE -> ID_REQ -> ID_WAIT -> TS_REQ -> TS_WAIT -> FIN -> IDLE.
//   IDLE: start=1, or first cycle after reset release when AUTO_START=1 -> ID_REQ;
//    clears id_ok, ts_ok, timeout, read_id, read_ts on that transition.
//   ID_REQ: avm_read=1, avm_address=0; advance to ID_WAIT in cycle waitrequest=0.
//   ID_WAIT: avm_read=0; on readdatavalid capture read_id, id_ok<=(readdata==EXP_ID) -> TS_REQ.
//   TS_REQ/TS_WAIT: same with address 1, read_ts, ts_ok vs EXP_TS -> FIN.
//   FIN: done=1 for one cycle, busy=0 next cycle -> IDLE.
//  readdatavalid accepted in same cycle the request is accepted (zero-latency fabric):
//   REQ state with waitrequest=0 and readdatavalid=1 captures and skips WAIT.
//  Outputs registered; avm_read/avm_address driven from state (no comb path from inputs).
//  busy=1 in every state except IDLE.
//  Timeout: counter clears on entering each REQ state, increments each cycle in REQ/WAIT;
//   reaching TIMEOUT_CYC-1 -> timeout<=1, avm_read<=0, go FIN (ok flags of unread words stay 0).
//  Only one read outstanding; readdatavalid outside WAIT/REQ ignored.
//  start during busy ignored; start in the FIN cycle ignored; start in IDLE accepted.
// STRUCTURE
//  Package sysid_chk_pkg: state enum, ADDR_ID=1'b0, ADDR_TS=1'b1.
//  Single module; timeout counter width $clog2(TIMEOUT_CYC). No sub-module needed.
// TESTING
//  1 AUTO_START=1, slave returns 0x04000000/0x5465DE70, waitrequest=0, latency 1
//    -> read sequence addr 0 then 1, done pulse, id_ok=ts_ok=1, timeout=0.
//  2 waitrequest held 5 cycles per read, latency 3 -> avm_read/address stable while
//    stalled, exactly 2 reads issued, pass flags as in 1.
//  3 TS returns 0x5465DE71 via start pulse -> id_ok=1, ts_ok=0, read_ts=0x5465DE71.
//  4 readdatavalid never asserted, TIMEOUT_CYC=16 -> done 16 cycles after ID request
//    entry (+FIN), timeout=1, id_ok=ts_ok=0, avm_read low.
//  5 reset asserted in ID_WAIT, stale readdatavalid after release with AUTO_START=0
//    -> all outputs 0, no done, no capture.
//  6 start pulsed while busy and in FIN -> ignored; single done per accepted start.

Source files
------------

// File: rtl/sysid_chk_pkg.sv
// Shared types for the system-ID checker master: FSM encoding and sysid word addresses.
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID_REQ,
    S_ID_WAIT,
    S_TS_REQ,
    S_TS_WAIT,
    S_FIN
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker_master.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares them
// against the expected hardware image, exposing sticky pass/timeout flags.
module sysid_checker_master
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXP_ID      = 32'h0400_0000,
  parameter logic [31:0] EXP_TS      = 32'h5465_DE70,
  parameter bit          AUTO_START  = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic             auto_pend;
  logic [CNT_W-1:0] cnt;

  logic is_req;
  logic is_ts;
  logic accept;
  logic got;
  logic tmo;

  always_comb begin
    is_req = (state == S_ID_REQ) || (state == S_TS_REQ);
    is_ts  = (state == S_TS_REQ) || (state == S_TS_WAIT);
    accept = is_req && !avm_waitrequest;
    // Zero-latency fabric: data may arrive in the very cycle the request is accepted.
    got    = avm_readdatavalid && (accept || !is_req);
    tmo    = (cnt == CNT_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      auto_pend   <= AUTO_START;
      cnt         <= '0;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      read_id     <= '0;
      read_ts     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || auto_pend) begin
            auto_pend   <= 1'b0;
            state       <= S_ID_REQ;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            cnt         <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            read_id     <= '0;
            read_ts     <= '0;
          end
        end
        S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
          if (got) begin
            avm_read <= 1'b0;
            if (!is_ts) begin
              read_id     <= avm_readdata;
              id_ok       <= (avm_readdata == EXP_ID);
              state       <= S_TS_REQ;
              avm_read    <= 1'b1;
              avm_address <= ADDR_TS;
              cnt         <= '0;
            end else begin
              read_ts <= avm_readdata;
              ts_ok   <= (avm_readdata == EXP_TS);
              state   <= S_FIN;
              done    <= 1'b1;
            end
          end else if (tmo) begin
            timeout  <= 1'b1;
            avm_read <= 1'b0;
            state    <= S_FIN;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (accept) begin
              avm_read <= 1'b0;
              state    <= is_ts ? S_TS_WAIT : S_ID_WAIT;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker_master.sv
// Directed bench for sysid_checker_master: auto-start, stalls, mismatch, timeout,
// zero-latency response, mid-read reset and start-while-busy handling.
module tb_sysid_checker_master;

  localparam logic [31:0] EXP_ID = 32'h0400_0000;
  localparam logic [31:0] EXP_TS = 32'h5465_DE70;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: auto-start, short timeout
  logic        reset, start, waitreq, rdv;
  logic [31:0] rdata;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] read_id, read_ts;

  // Instance B: no auto-start, used for the mid-read reset scenario
  logic        b_reset, b_start, b_waitreq, b_rdv;
  logic [31:0] b_rdata;
  logic        b_avm_address, b_avm_read, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
  logic [31:0] b_read_id, b_read_ts;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int b_done_cnt = 0;

  sysid_checker_master #(
    .EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .AUTO_START(1'b1), .TIMEOUT_CYC(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(waitreq),
    .avm_readdata(rdata), .avm_readdatavalid(rdv),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .read_id(read_id), .read_ts(read_ts)
  );

  sysid_checker_master #(
    .EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .AUTO_START(1'b0), .TIMEOUT_CYC(16)
  ) dut_b (
    .clock(clock), .reset(b_reset), .start(b_start),
    .avm_address(b_avm_address), .avm_read(b_avm_read), .avm_waitrequest(b_waitreq),
    .avm_readdata(b_rdata), .avm_readdatavalid(b_rdv),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok), .timeout(b_timeout),
    .read_id(b_read_id), .read_ts(b_read_ts)
  );

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (b_done === 1'b1) b_done_cnt++;
  end

  always @(posedge clock) if (avm_read === 1'b1 && waitreq === 1'b0) acc_cnt++;

  // Serve one read: ws stall cycles, response lat cycles after acceptance (0 = same cycle).
  task automatic slave_read(input int ws, input int lat, input logic [31:0] data,
                            input logic exp_addr);
    int n = 0;
    while (avm_read !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if (avm_read !== 1'b1) begin
      n_fail++; $display("FAIL read_req: avm_read=%b required 1", avm_read); return;
    end
    n_checks++;
    if (avm_address !== exp_addr) begin
      n_fail++; $display("FAIL read_addr: avm_address=%b required %b", avm_address, exp_addr);
    end
    for (int i = 0; i < ws; i++) begin
      waitreq = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({avm_read, avm_address} !== {1'b1, exp_addr}) begin
        n_fail++; $display("FAIL stall_hold: read/addr=%b%b required 1%b", avm_read, avm_address, exp_addr);
      end
    end
    waitreq = 1'b0;
    if (lat == 0) begin rdv = 1'b1; rdata = data; end
    @(negedge clock);
    rdv = 1'b0; rdata = '0;
    if (lat > 0) begin
      n_checks++;
      if (avm_read !== 1'b0) begin
        n_fail++; $display("FAIL read_drop: avm_read=%b required 0 after accept", avm_read);
      end
      for (int i = 1; i < lat; i++) @(negedge clock);
      rdv = 1'b1; rdata = data;
      @(negedge clock);
      rdv = 1'b0; rdata = '0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clock); n++; end
    n_checks++;
    if ({done, busy} !== 2'b11) begin
      n_fail++; $display("FAIL done_pulse: done/busy=%b%b required 11", done, busy);
    end
    @(negedge clock);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL done_end: done/busy=%b%b required 00", done, busy);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, read_id, read_ts} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs nonzero busy=%b read=%b id=%h", busy, avm_read, read_id);
    end
    n_checks++;
    if ({b_avm_read, b_avm_address, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout, b_read_id, b_read_ts} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs nonzero busy=%b read=%b", b_busy, b_avm_read);
    end
  endtask

  task automatic test_auto_start();
    done_cnt = 0; acc_cnt = 0;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, avm_read} !== 2'b11) begin
      n_fail++; $display("FAIL auto_start: busy/read=%b%b required 11", busy, avm_read);
    end
    slave_read(0, 1, EXP_ID, 1'b0);
    slave_read(0, 1, EXP_TS, 1'b1);
    wait_done();
    n_checks++;
    if ({id_ok, ts_ok, timeout, read_id, read_ts} !== {3'b110, EXP_ID, EXP_TS}) begin
      n_fail++; $display("FAIL auto_flags: id/ts/to=%b%b%b id=%h ts=%h required 110", id_ok, ts_ok, timeout, read_id, read_ts);
    end
    n_checks++;
    if (done_cnt !== 1 || acc_cnt !== 2) begin
      n_fail++; $display("FAIL auto_counts: done=%0d reads=%0d required 1 2", done_cnt, acc_cnt);
    end
  endtask

  task automatic test_stall();
    acc_cnt = 0;
    pulse_start();
    slave_read(5, 3, EXP_ID, 1'b0);
    slave_read(5, 3, EXP_TS, 1'b1);
    wait_done();
    n_checks++;
    if (acc_cnt !== 2) begin
      n_fail++; $display("FAIL stall_reads: reads=%0d required 2", acc_cnt);
    end
    n_checks++;
    if ({id_ok, ts_ok, timeout} !== 3'b110) begin
      n_fail++; $display("FAIL stall_flags: id/ts/to=%b%b%b required 110", id_ok, ts_ok, timeout);
    end
  endtask

  task automatic test_ts_mismatch();
    pulse_start();
    n_checks++;
    if ({id_ok, ts_ok, read_id} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL start_clear: id/ts=%b%b id=%h required 00 0", id_ok, ts_ok, read_id);
    end
    slave_read(0, 1, EXP_ID, 1'b0);
    slave_read(0, 1, 32'h5465_DE71, 1'b1);
    wait_done();
    n_checks++;
    if ({id_ok, ts_ok, timeout, read_ts} !== {3'b100, 32'h5465_DE71}) begin
      n_fail++; $display("FAIL ts_mismatch: id/ts/to=%b%b%b ts=%h required 100 5465de71", id_ok, ts_ok, timeout, read_ts);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    pulse_start();
    n_checks++;
    if (avm_read !== 1'b1) begin
      n_fail++; $display("FAIL tmo_req: avm_read=%b required 1", avm_read);
    end
    while (done !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if (n !== 16) begin
      n_fail++; $display("FAIL tmo_latency: done after %0d cycles required 16", n);
    end
    n_checks++;
    if ({timeout, id_ok, ts_ok, avm_read, read_id} !== {4'b1000, 32'h0}) begin
      n_fail++; $display("FAIL tmo_flags: to/id/ts/read=%b%b%b%b required 1000", timeout, id_ok, ts_ok, avm_read);
    end
    @(negedge clock);
    // Timeout on the second word keeps the first word's result.
    pulse_start();
    slave_read(0, 1, EXP_ID, 1'b0);
    wait_done();
    n_checks++;
    if ({timeout, id_ok, ts_ok} !== 3'b110) begin
      n_fail++; $display("FAIL tmo_ts_flags: to/id/ts=%b%b%b required 110", timeout, id_ok, ts_ok);
    end
  endtask

  task automatic test_zero_latency();
    pulse_start();
    slave_read(0, 0, EXP_ID, 1'b0);
    n_checks++;
    if ({avm_read, avm_address, id_ok} !== 3'b111) begin
      n_fail++; $display("FAIL zl_skip: read/addr/id_ok=%b%b%b required 111", avm_read, avm_address, id_ok);
    end
    slave_read(0, 0, EXP_TS, 1'b1);
    n_checks++;
    if ({done, id_ok, ts_ok, timeout} !== 4'b1110) begin
      n_fail++; $display("FAIL zl_done: done/id/ts/to=%b%b%b%b required 1110", done, id_ok, ts_ok, timeout);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    pulse_start();
    start = 1'b1;
    slave_read(0, 1, EXP_ID, 1'b0);
    slave_read(0, 1, EXP_TS, 1'b1);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: done=%b required 1", done);
    end
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if ({busy, avm_read} !== 2'b00 || done_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_ignore: busy/read=%b%b dones=%0d required 00 1", busy, avm_read, done_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    b_reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (b_busy !== 1'b0) begin
      n_fail++; $display("FAIL no_auto: busy=%b required 0", b_busy);
    end
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({b_busy, b_avm_read} !== 2'b10) begin
      n_fail++; $display("FAIL b_id_wait: busy/read=%b%b required 10", b_busy, b_avm_read);
    end
    b_reset = 1'b1;
    #1;
    n_checks++;
    if (b_busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: busy=%b required 0", b_busy);
    end
    @(negedge clock);
    b_reset = 1'b0;
    b_rdv = 1'b1; b_rdata = EXP_ID;
    repeat (2) @(negedge clock);
    b_rdv = 1'b0; b_rdata = '0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({b_avm_read, b_busy, b_id_ok, b_ts_ok, b_timeout, b_read_id, b_read_ts} !== '0 || b_done_cnt !== 0) begin
      n_fail++; $display("FAIL stale_rdv: busy=%b id_ok=%b id=%h dones=%0d required all 0", b_busy, b_id_ok, b_read_id, b_done_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; waitreq = 1'b0; rdv = 1'b0; rdata = '0;
    b_reset = 1'b1; b_start = 1'b0; b_waitreq = 1'b0; b_rdv = 1'b0; b_rdata = '0;
    test_reset();
    test_auto_start();
    test_stall();
    test_ts_mismatch();
    test_timeout();
    test_zero_latency();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
